// File: rtl/mult_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states, Booth opcodes
// and the opcode decode helper used by booth_step.
package mult_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } booth_op_e;

    // Radix-2 Booth recoding of the {Q[0], q_1} bit pair.
    function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
        case ({q0, q_m1})
            2'b01:   return ADD;
            2'b10:   return SUB;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: add/subtract M into A as selected
// by {Q[0], q_1}, then arithmetic shift of {A, Q, q_1} right by one bit.
module booth_step
    import mult_pkg::*;
#(
    parameter int AW = 33,
    parameter int QW = 32
) (
    input  logic [AW-1:0] a_in,
    input  logic [QW-1:0] q_in,
    input  logic          q_1_in,
    input  logic [AW-1:0] m_in,
    output logic [AW-1:0] a_out,
    output logic [QW-1:0] q_out,
    output logic          q_1_out
);

    booth_op_e     op;
    logic [AW-1:0] sum;

    always_comb begin
        op  = booth_decode(q_in[0], q_1_in);
        sum = a_in;
        case (op)
            ADD:     sum = a_in + m_in;
            SUB:     sum = a_in - m_in;
            default: sum = a_in;
        endcase
        a_out   = {sum[AW-1], sum[AW-1:1]};
        q_out   = {sum[0], q_in[QW-1:1]};
        q_1_out = q_in[0];
    end

endmodule

// File: rtl/mult_booth.sv
// Sequential signed WIDTHxWIDTH radix-2 Booth multiplier, one step per clock,
// start/end handshake and Hi/Lo result like the divider. MULT_UNSIGNED_EN adds MULTU.
module mult_booth
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MULT_UNSIGNED_EN
    input  logic             mult_unsigned,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mult_busy,
    output logic             mult_end
);

`ifdef MULT_UNSIGNED_EN
    localparam int STEPS = WIDTH + 1;
    localparam int QW    = WIDTH + 1;
`else
    localparam int STEPS = WIDTH;
    localparam int QW    = WIDTH;
`endif
    localparam int CW = $clog2(STEPS + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [QW-1:0]    q_q, q_d;
    logic             q1_q, q1_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             end_q, end_d;

    logic [WIDTH:0]   acc_step;
    logic [QW-1:0]    q_step;
    logic             q1_step;
    logic             ext_a, ext_b;

    booth_step #(
        .AW (WIDTH + 1),
        .QW (QW)
    ) u_step (
        .a_in    (acc_q),
        .q_in    (q_q),
        .q_1_in  (q1_q),
        .m_in    (m_q),
        .a_out   (acc_step),
        .q_out   (q_step),
        .q_1_out (q1_step)
    );

`ifdef MULT_UNSIGNED_EN
    assign ext_a = mult_unsigned ? 1'b0 : a[WIDTH-1];
    assign ext_b = mult_unsigned ? 1'b0 : b[WIDTH-1];
`else
    assign ext_a = a[WIDTH-1];
    assign ext_b = b[WIDTH-1];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (mult_start) begin
                    m_d     = {ext_a, a};
                    acc_d   = '0;
`ifdef MULT_UNSIGNED_EN
                    q_d     = {ext_b, b};
`else
                    q_d     = b;
`endif
                    q1_d    = 1'b0;
                    cnt_d   = CW'(STEPS);
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_step;
                q_d   = q_step;
                q1_d  = q1_step;
                cnt_d = cnt_q - CW'(1);
                // Last step: publish the product straight from the step result.
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
`ifdef MULT_UNSIGNED_EN
                    hi_d = {acc_step[WIDTH-2:0], q_step[WIDTH]};
                    lo_d = q_step[WIDTH-1:0];
`else
                    hi_d = acc_step[WIDTH-1:0];
                    lo_d = q_step;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        end_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            end_q   <= end_d;
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign mult_busy = busy_q;
    assign mult_end  = end_q;

endmodule
